// File: rtl/mem_bus_interface.sv
// Bridge between the internal address/data buses and external memory.
// One read or write access per request, with RDY wait states and a bounded timeout.
module mem_bus_interface #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [7:0]  ADL_BUS,
    input  logic [7:0]  ADH_BUS,
    input  logic [7:0]  DB_DATA,
    output logic        BUSY,
    output logic        ACK,
    output logic        TIMEOUT,
    output logic [7:0]  DL_OUT,
    output logic [15:0] A,
    output logic [7:0]  D_OUT,
    input  logic [7:0]  D_IN,
    output logic        RW,
    output logic        MEM_EN,
    input  logic        RDY
);

    // A zero-width counter is not legal, so MAX_WAIT=0 still gets one bit.
    localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      dl_q, dl_d;
    logic            mem_en_q, mem_en_d;
    logic            ack_q, ack_d;
    logic            timeout_q, timeout_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            addr_q    <= 16'h0000;
            rw_q      <= 1'b1;
            dout_q    <= 8'h00;
            dl_q      <= 8'h00;
            mem_en_q  <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            dout_q    <= dout_d;
            dl_q      <= dl_d;
            mem_en_q  <= mem_en_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        dout_d    = dout_q;
        dl_d      = dl_q;
        mem_en_d  = mem_en_q;
        ack_d     = 1'b0;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (REQ) begin
                    addr_d  = {ADH_BUS, ADL_BUS};
                    rw_d    = ~WE;
                    if (WE) begin
                        dout_d = DB_DATA;
                    end
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                // Address has been stable for a full cycle before the strobe rises.
                mem_en_d = 1'b1;
                state_d  = StStrobe;
            end
            StStrobe: begin
                if (RDY) begin
                    if (rw_q) begin
                        dl_d = D_IN;
                    end
                    mem_en_d = 1'b0;
                    ack_d    = 1'b1;
                    state_d  = StIdle;
                end else if (cnt_q == MaxCnt) begin
                    mem_en_d  = 1'b0;
                    ack_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign BUSY    = (state_q != StIdle);
    assign ACK     = ack_q;
    assign TIMEOUT = timeout_q;
    assign DL_OUT  = dl_q;
    assign A       = addr_q;
    assign D_OUT   = dout_q;
    assign RW      = rw_q;
    assign MEM_EN  = mem_en_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
// Scoreboard bench for mem_bus_interface: expected completions are queued at request
// time and compared when the DUT raises ACK.
module tb_mem_bus_interface;

    localparam int unsigned MaxWait = 3;

    logic        CLK = 1'b0;
    logic        RST, REQ, WE, RDY;
    logic [7:0]  ADL_BUS, ADH_BUS, DB_DATA, D_IN;
    logic        BUSY, ACK, TIMEOUT, RW, MEM_EN;
    logic [7:0]  DL_OUT, D_OUT;
    logic [15:0] A;

    mem_bus_interface #(.MAX_WAIT(MaxWait)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .WE      (WE),
        .ADL_BUS (ADL_BUS),
        .ADH_BUS (ADH_BUS),
        .DB_DATA (DB_DATA),
        .BUSY    (BUSY),
        .ACK     (ACK),
        .TIMEOUT (TIMEOUT),
        .DL_OUT  (DL_OUT),
        .A       (A),
        .D_OUT   (D_OUT),
        .D_IN    (D_IN),
        .RW      (RW),
        .MEM_EN  (MEM_EN),
        .RDY     (RDY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] dl;
        logic       to;
        int         lat;
        int         men;
    } exp_t;

    exp_t       sb[$];
    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] dl_model = 8'h00;
    logic [7:0] dout_model = 8'h00;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = 1'b1; WE = 1'b1; RDY = 1'b1;
        {ADH_BUS, ADL_BUS} = 16'h5A5A; DB_DATA = 8'hEE; D_IN = 8'h00;
        tick();
        tick();
        // RST outranks a pending REQ.
        vec_cnt++;
        if (BUSY !== 1'b0 || ACK !== 1'b0 || TIMEOUT !== 1'b0 || MEM_EN !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: busy=%b ack=%b to=%b men=%b, want 0000",
                     BUSY, ACK, TIMEOUT, MEM_EN);
        end
        vec_cnt++;
        if (RW !== 1'b1 || A !== 16'h0000 || D_OUT !== 8'h00 || DL_OUT !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_data: rw=%b a=%h dout=%h dl=%h, want 1 0000 00 00",
                     RW, A, D_OUT, DL_OUT);
        end
        REQ = 1'b0; RST = 1'b0;
        tick();
        vec_cnt++;
        if (BUSY !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_idle: busy=%b, want 0", BUSY);
        end
    endtask

    // Drives one access; RDY stays low for `waits` strobe cycles (large = timeout).
    task automatic do_access(input string nm, input logic we, input logic [15:0] addr,
                             input logic [7:0] wdata, input logic [7:0] rdata,
                             input int waits);
        exp_t e, g;
        int   lat, men, scnt;
        e.to  = (waits > int'(MaxWait));
        e.lat = e.to ? 3 + int'(MaxWait) : 3 + waits;
        e.men = e.lat - 2;
        e.dl  = (!we && !e.to) ? rdata : dl_model;
        sb.push_back(e);
        if (we) dout_model = wdata;

        {ADH_BUS, ADL_BUS} = addr; WE = we; DB_DATA = wdata; D_IN = rdata;
        RDY = 1'b1; REQ = 1'b1;
        tick();
        REQ = 1'b0;
        vec_cnt++;
        if (A !== addr || RW !== ~we || BUSY !== 1'b1 || MEM_EN !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_accept: a=%h rw=%b busy=%b men=%b, want %h %b 1 0",
                     nm, A, RW, BUSY, MEM_EN, addr, ~we);
        end
        vec_cnt++;
        if (D_OUT !== dout_model) begin
            err_cnt++;
            $display("FAIL %s_dout: got %h want %h", nm, D_OUT, dout_model);
        end

        lat = 1; men = 0; scnt = 0;
        while (ACK !== 1'b1 && lat < 40) begin
            if (MEM_EN === 1'b1) begin
                men++;
                RDY = (scnt >= waits);
                scnt++;
            end else begin
                RDY = 1'b1;  // RDY outside STROBE must be ignored
            end
            tick();
            lat++;
        end
        RDY = 1'b1;
        if (ACK !== 1'b1) begin
            err_cnt++;
            vec_cnt++;
            $display("FAIL %s_no_ack: ack=%b after %0d cycles, want 1", nm, ACK, lat);
            void'(sb.pop_front());
            return;
        end
        g = sb.pop_front();
        if (!e.to && !we) dl_model = rdata;
        vec_cnt++;
        if (lat !== g.lat || men !== g.men) begin
            err_cnt++;
            $display("FAIL %s_timing: lat=%0d men=%0d, want %0d %0d", nm, lat, men, g.lat, g.men);
        end
        vec_cnt++;
        if (DL_OUT !== g.dl || TIMEOUT !== g.to) begin
            err_cnt++;
            $display("FAIL %s_result: dl=%h to=%b, want %h %b", nm, DL_OUT, TIMEOUT, g.dl, g.to);
        end
        vec_cnt++;
        if (BUSY !== 1'b0 || MEM_EN !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_ack_cycle: busy=%b men=%b, want 0 0", nm, BUSY, MEM_EN);
        end
        tick();
        vec_cnt++;
        if (ACK !== 1'b0 || TIMEOUT !== 1'b0 || A !== addr || RW !== ~we || D_OUT !== dout_model) begin
            err_cnt++;
            $display("FAIL %s_after: ack=%b to=%b a=%h rw=%b dout=%h, want 0 0 %h %b %h",
                     nm, ACK, TIMEOUT, A, RW, D_OUT, addr, ~we, dout_model);
        end
    endtask

    task automatic test_read();
        do_access("read", 1'b0, 16'h12AB, 8'h00, 8'h5C, 0);
    endtask

    task automatic test_write_wait();
        do_access("write", 1'b1, 16'hFFFE, 8'hA5, 8'h77, 2);
    endtask

    task automatic test_timeout();
        do_access("timeout", 1'b0, 16'h4321, 8'h11, 8'h99, 255);
        do_access("read_after_to", 1'b0, 16'h0F0F, 8'h22, 8'h3C, 3);
    endtask

    task automatic test_back_to_back();
        exp_t g;
        {ADH_BUS, ADL_BUS} = 16'h0000; WE = 1'b0; RDY = 1'b1; D_IN = 8'hC0;
        REQ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.dl = 8'hC0 + 8'(i); e.to = 1'b0; e.lat = 3; e.men = 1;
            sb.push_back(e);
            tick();
            vec_cnt++;
            if (A !== 16'(i) || BUSY !== 1'b1 || ACK !== 1'b0) begin
                err_cnt++;
                $display("FAIL b2b_accept%0d: a=%h busy=%b ack=%b, want %h 1 0",
                         i, A, BUSY, ACK, 16'(i));
            end
            if (i == 2) REQ = 1'b0;
            {ADH_BUS, ADL_BUS} = 16'(i + 1);  // bus moves on; ignored while busy
            tick();
            tick();
            g = sb.pop_front();
            vec_cnt++;
            if (ACK !== 1'b1 || DL_OUT !== g.dl || A !== 16'(i)) begin
                err_cnt++;
                $display("FAIL b2b_ack%0d: ack=%b dl=%h a=%h, want 1 %h %h",
                         i, ACK, DL_OUT, A, g.dl, 16'(i));
            end
            dl_model = g.dl;
            D_IN = 8'hC0 + 8'(i + 1);
        end
        tick();
        vec_cnt++;
        if (BUSY !== 1'b0 || A !== 16'h0002 || ACK !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_end: busy=%b a=%h ack=%b, want 0 0002 0", BUSY, A, ACK);
        end
    endtask

    task automatic test_reset_mid_access();
        int acks;
        {ADH_BUS, ADL_BUS} = 16'h3456; WE = 1'b0; RDY = 1'b1; D_IN = 8'h81;
        REQ = 1'b1;
        tick();
        {ADH_BUS, ADL_BUS} = 16'hBEEF;  // REQ still high during SETUP
        tick();
        REQ = 1'b0; RDY = 1'b0;
        vec_cnt++;
        if (A !== 16'h3456 || MEM_EN !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_setup_req: a=%h men=%b, want 3456 1", A, MEM_EN);
        end
        REQ = 1'b1;  // REQ pulse during STROBE
        tick();
        REQ = 1'b0;
        vec_cnt++;
        if (A !== 16'h3456 || MEM_EN !== 1'b1 || ACK !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_strobe_req: a=%h men=%b ack=%b, want 3456 1 0", A, MEM_EN, ACK);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0; RDY = 1'b1;
        vec_cnt++;
        if (ACK !== 1'b0 || MEM_EN !== 1'b0 || RW !== 1'b1 || A !== 16'h0000 ||
            DL_OUT !== 8'h00 || D_OUT !== 8'h00 || BUSY !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_mid: ack=%b men=%b rw=%b a=%h dl=%h dout=%h busy=%b, want 0 0 1 0000 00 00 0",
                     ACK, MEM_EN, RW, A, DL_OUT, D_OUT, BUSY);
        end
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (ACK === 1'b1) acks++;
            tick();
        end
        vec_cnt++;
        if (acks !== 0) begin
            err_cnt++;
            $display("FAIL rst_no_ack: got %0d acks want 0", acks);
        end
        dl_model = 8'h00; dout_model = 8'h00;
        do_access("read_after_rst", 1'b0, 16'h00FF, 8'h00, 8'h6D, 1);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_bus_interface.md
# mem_bus_interface

Bridge between the internal address/data buses and external memory. Latches an address from ADH/ADL, and write data from DB, into the address bus register and data output register. Runs one read or write access with RDY-driven wait states and a timeout. Returns read data through the input data latch for the datapath to put back onto DB.

## Interface
- MAX_WAIT, 15: maximum number of RDY-low cycles tolerated in STROBE before the access is aborted (0..255).
- CLK  in  1  core clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- REQ  in  1  access request; sampled only in IDLE.
- WE  in  1  1 = write, 0 = read; sampled with REQ.
- ADL_BUS  in  8  address low byte; sampled with REQ.
- ADH_BUS  in  8  address high byte; sampled with REQ.
- DB_DATA  in  8  write data from the internal data bus; sampled with REQ when WE=1.
- BUSY  out  1  high in SETUP and STROBE.
- ACK  out  1  one-cycle completion pulse.
- TIMEOUT  out  1  one-cycle pulse, coincident with ACK, when the access was aborted.
- DL_OUT  out  8  input data latch, toward DB.
- A  out  16  external address, {ADH, ADL}.
- D_OUT  out  8  external write data (data output register).
- D_IN  in  8  external read data.
- RW  out  1  1 = read, 0 = write.
- MEM_EN  out  1  memory strobe.
- RDY  in  1  memory ready; meaningful only while MEM_EN=1.

## Operation
- FSM states: IDLE, SETUP, STROBE.
- IDLE, REQ=1 at an edge:
  - A <= {ADH_BUS, ADL_BUS}.
  - RW <= ~WE.
  - If WE=1, D_OUT <= DB_DATA; if WE=0, D_OUT holds.
  - Wait counter <= 0; go to SETUP.
- IDLE, REQ=0: all outputs hold.
- SETUP: exactly one cycle with the address stable and MEM_EN=0. Next edge: MEM_EN <= 1, go to STROBE.
- STROBE, RDY=1 at an edge:
  - If read, DL_OUT <= D_IN; if write, DL_OUT holds.
  - MEM_EN <= 0, ACK <= 1, go to IDLE.
- STROBE, RDY=0 at an edge:
  - If counter == MAX_WAIT: abort. MEM_EN <= 0, ACK <= 1, TIMEOUT <= 1, DL_OUT holds, go to IDLE.
  - Otherwise: counter <= counter + 1.
- Counter width is clog2(MAX_WAIT+1). It never wraps, because the abort fires first.
- A, RW and D_OUT hold after completion until the next accepted request.
- REQ while BUSY=1 is ignored; nothing is queued.
- REQ still high in the ACK cycle (state is IDLE) is accepted at that edge, giving back-to-back accesses.
- RDY is ignored in IDLE and SETUP.
- MAX_WAIT=0: abort if RDY=0 at the first STROBE edge.

## Timing
- Reset values: state IDLE, BUSY=0, ACK=0, TIMEOUT=0, MEM_EN=0, RW=1, A=0x0000, D_OUT=0x00, DL_OUT=0x00, counter=0.
- RST=1 mid-access aborts it immediately at that edge: no ACK, MEM_EN drops, reset values are applied.
- RST has priority over every other input.
- REQ sampled at edge n:
  - A/RW valid and BUSY=1 after edge n.
  - MEM_EN=1 after edge n+1.
- Zero wait states (RDY=1 at edge n+2): ACK and DL_OUT valid after edge n+2, so the access takes 3 cycles.
- k wait states: ACK after edge n+2+k.
- Timeout: ACK/TIMEOUT after edge n+2+MAX_WAIT. MEM_EN is high for MAX_WAIT+1 cycles.
- Maximum throughput with REQ held high: one access per 3 cycles. Accept edges are n, n+3, n+6, ...
- ACK and TIMEOUT are registered and are high for exactly one cycle.
- BUSY is combinational from state: 0 in the ACK cycle.

## Test plan
- Reset, then read 0x12AB with RDY tied 1 and D_IN=0x5C:
  - A=0x12AB and RW=1 one cycle after REQ.
  - MEM_EN high for one cycle.
  - ACK 3 cycles after REQ, DL_OUT=0x5C.
- Write 0xFFFE with DB_DATA=0xA5 and RDY low for 2 strobe cycles:
  - RW=0, D_OUT=0xA5.
  - ACK 5 cycles after REQ, DL_OUT unchanged, TIMEOUT=0.
- MAX_WAIT=3 with RDY held 0:
  - MEM_EN high for 4 cycles.
  - ACK and TIMEOUT pulse together 6 cycles after REQ; DL_OUT unchanged.
  - Then a normal read succeeds.
- REQ held high for 3 reads at 0x0000/0x0001/0x0002 with the bus changing:
  - Accepts occur every 3 cycles, at the ACK edges.
  - Each DL_OUT matches D_IN for its address.
- RST pulsed during STROBE:
  - No ACK; MEM_EN=0, RW=1, A=0x0000, DL_OUT=0x00 the next cycle.
  - Pulsing REQ during SETUP/STROBE is ignored.
